// File: rtl/mux_pkg.sv
// Shared types and index helpers for the mux serializer slice.
package mux_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam int unsigned DEF_WIDTH = 8;

   function automatic int unsigned start_index(input int unsigned width, input bit msb_first);
      return msb_first ? width - 1 : 0;
   endfunction

   function automatic int unsigned end_index(input int unsigned width, input bit msb_first);
      return msb_first ? 0 : width - 1;
   endfunction

endpackage

// File: rtl/muxer.sv
// 8:1 bit multiplexer: q = in[sel].
module muxer (
   input  logic [7:0] in,
   input  logic [2:0] sel,
   output logic       q
);

   assign q = in[sel];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage: latches a word on a valid/ready handshake and
// walks the mux select through every bit, marking the final bit with q_last.
module mux_serializer
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned SEL_W     = $clog2(WIDTH),
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic             q_last,
   output logic [SEL_W-1:0] sel
);

   localparam logic [SEL_W-1:0] START = SEL_W'(start_index(WIDTH, MSB_FIRST));
   localparam logic [SEL_W-1:0] STOP  = SEL_W'(end_index(WIDTH, MSB_FIRST));

   state_t           state;
   logic [WIDTH-1:0] data_reg;
   logic [SEL_W-1:0] sel_r;
   logic [SEL_W-1:0] sel_next;
   logic             mux_q;
   logic             beat;

   assign sel      = sel_r;
   assign beat     = q_valid && q_ready;
   assign sel_next = MSB_FIRST ? (sel_r - SEL_W'(1)) : (sel_r + SEL_W'(1));

   // A new word is only taken when idle, or in the same cycle the last bit leaves.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         if (state == IDLE) in_ready = 1'b1;
         else               in_ready = beat && q_last;
      end
   end

   generate
      if (WIDTH == 8) begin : g_muxer
         muxer u_muxer (
            .in  (data_reg),
            .sel (sel_r),
            .q   (mux_q)
         );
      end else begin : g_index
         assign mux_q = data_reg[sel_r];
      end
   endgenerate

   assign q = q_valid & mux_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sel_r    <= START;
         data_reg <= '0;
         q_valid  <= 1'b0;
         q_last   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_reg <= in_data;
                  sel_r    <= START;
                  state    <= SHIFT;
                  q_valid  <= 1'b1;
                  q_last   <= (START == STOP);
               end
            end
            SHIFT: begin
               if (beat) begin
                  if (q_last) begin
                     // Final-beat reload takes the place of the select step, so sel never wraps.
                     sel_r  <= START;
                     q_last <= 1'b0;
                     if (in_valid) begin
                        data_reg <= in_data;
                     end else begin
                        state   <= IDLE;
                        q_valid <= 1'b0;
                     end
                  end else begin
                     sel_r  <= sel_next;
                     q_last <= (sel_next == STOP);
                  end
               end
            end
            default: begin
               state   <= IDLE;
               q_valid <= 1'b0;
               q_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench for mux_serializer: LSB-first and MSB-first instances.
module tb_mux_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data, in_data2;
   logic       in_valid, in_valid2;
   logic       in_ready, in_ready2;
   logic       q, q2;
   logic       q_valid, q_valid2;
   logic       q_ready, q_ready2;
   logic       q_last, q_last2;
   logic [2:0] sel, sel2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mux_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .q(q), .q_valid(q_valid), .q_ready(q_ready), .q_last(q_last), .sel(sel)
   );

   mux_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
      .q(q2), .q_valid(q_valid2), .q_ready(q_ready2), .q_last(q_last2), .sel(sel2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input string tag, input logic eq, input logic [2:0] es, input logic el);
      chk({tag, ".q_valid"}, 32'(q_valid), 32'd1);
      chk({tag, ".q"},       32'(q),       32'(eq));
      chk({tag, ".sel"},     32'(sel),     32'(es));
      chk({tag, ".q_last"},  32'(q_last),  32'(el));
   endtask

   logic [7:0] w;

   initial begin
      rst = 1'b1; in_data = '0; in_valid = 1'b0; q_ready = 1'b0;
      in_data2 = '0; in_valid2 = 1'b0; q_ready2 = 1'b0;

      // Test 1: reset, then 8'hA5
      repeat (3) next_cycle();
      #1;
      chk("rst.q_valid", 32'(q_valid), 32'd0);
      chk("rst.q_last",  32'(q_last),  32'd0);
      chk("rst.q",       32'(q),       32'd0);
      chk("rst.sel",     32'(sel),     32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.sel_msb", 32'(sel2),    32'd7);
      next_cycle();
      rst = 1'b0; q_ready = 1'b1; in_data = 8'hA5; in_valid = 1'b1;
      #1;
      chk("t1.in_ready_idle", 32'(in_ready), 32'd1);
      w = 8'hA5;
      next_cycle();
      in_valid = 1'b0; in_data = 8'h00;
      for (int unsigned i = 0; i < 8; i++) begin
         #1;
         beat("t1", w[i], 3'(i), i == 7);
         chk("t1.in_ready", 32'(in_ready), 32'(i == 7));
         next_cycle();
      end
      #1;
      chk("t1.idle_q_valid", 32'(q_valid), 32'd0);
      chk("t1.idle_in_ready", 32'(in_ready), 32'd1);

      // Test 2: back-to-back 8'h01 then 8'hFE
      next_cycle();
      in_data = 8'h01; in_valid = 1'b1;
      next_cycle();
      in_data = 8'hFE;
      w = 8'h01;
      for (int unsigned i = 0; i < 8; i++) begin
         #1;
         beat("t2a", w[i], 3'(i), i == 7);
         chk("t2a.in_ready", 32'(in_ready), 32'(i == 7));
         next_cycle();
      end
      in_valid = 1'b0; in_data = 8'h00;
      w = 8'hFE;
      for (int unsigned i = 0; i < 8; i++) begin
         #1;
         beat("t2b", w[i], 3'(i), i == 7);
         chk("t2b.in_ready", 32'(in_ready), 32'(i == 7));
         next_cycle();
      end
      #1;
      chk("t2.idle_q_valid", 32'(q_valid), 32'd0);

      // Test 3: 8'h0F with a 4-cycle stall at sel=3
      next_cycle();
      in_data = 8'h0F; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      w = 8'h0F;
      for (int unsigned i = 0; i < 3; i++) begin
         #1;
         beat("t3", w[i], 3'(i), 1'b0);
         next_cycle();
      end
      q_ready = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         #1;
         beat("t3.stall", 1'b1, 3'd3, 1'b0);
         next_cycle();
      end
      q_ready = 1'b1;
      for (int unsigned i = 3; i < 8; i++) begin
         #1;
         beat("t3.resume", w[i], 3'(i), i == 7);
         next_cycle();
      end

      // Test 4: 8'hFF aborted by reset at sel=5, then 8'h02
      in_data = 8'hFF; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         #1;
         beat("t4", 1'b1, 3'(i), 1'b0);
         next_cycle();
      end
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h80;
      #1;
      chk("t4.rst_in_ready", 32'(in_ready), 32'd0);
      next_cycle();
      #1;
      chk("t4.abort_q_valid", 32'(q_valid), 32'd0);
      chk("t4.abort_sel",     32'(sel),     32'd0);
      chk("t4.abort_q_last",  32'(q_last),  32'd0);
      next_cycle();
      #1;
      chk("t4.rst_no_accept", 32'(q_valid), 32'd0);
      rst = 1'b0; in_data = 8'h02; in_valid = 1'b1;
      #1;
      chk("t4.in_ready", 32'(in_ready), 32'd1);
      next_cycle();
      in_valid = 1'b0;
      #1;
      beat("t4.b0", 1'b0, 3'd0, 1'b0);
      next_cycle();
      #1;
      beat("t4.b1", 1'b1, 3'd1, 1'b0);
      repeat (7) next_cycle();
      #1;
      chk("t4.idle", 32'(q_valid), 32'd0);

      // Test 5: MSB-first instance with 8'h80
      chk("t5.sel_idle", 32'(sel2), 32'd7);
      q_ready2 = 1'b1; in_data2 = 8'h80; in_valid2 = 1'b1;
      next_cycle();
      in_valid2 = 1'b0;
      w = 8'h80;
      for (int unsigned i = 0; i < 8; i++) begin
         #1;
         chk("t5.q_valid", 32'(q_valid2), 32'd1);
         chk("t5.sel",     32'(sel2),     32'(7 - i));
         chk("t5.q",       32'(q2),       32'(w[7 - i]));
         chk("t5.q_last",  32'(q_last2),  32'(i == 7));
         next_cycle();
      end
      #1;
      chk("t5.idle", 32'(q_valid2), 32'd0);

      // Test 6: 8'h55 with in_data toggling mid-frame; 8'hAA taken on final beat
      next_cycle();
      in_data = 8'h55; in_valid = 1'b1;
      next_cycle();
      w = 8'h55;
      for (int unsigned i = 0; i < 8; i++) begin
         in_data = (i % 2 == 1) ? 8'hAA : 8'h33;
         #1;
         beat("t6", w[i], 3'(i), i == 7);
         next_cycle();
      end
      in_valid = 1'b0; in_data = 8'h00;
      w = 8'hAA;
      for (int unsigned i = 0; i < 8; i++) begin
         #1;
         beat("t6.aa", w[i], 3'(i), i == 7);
         next_cycle();
      end
      #1;
      chk("t6.idle", 32'(q_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
